// File: rtl/spi_word_shifter.sv
// SPI mode-0 slave shifter: synchronizes the pins into clk, deserializes MOSI into
// words for the command FSM and serializes tx words onto MISO, MSB first.
module spi_word_shifter #(
   parameter int WORD_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sck,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [WORD_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [WORD_W-1:0] rx_data,
   output logic              done,
   output logic [3:0]        cmd,
   output logic [7:0]        word_cnt,
   output logic              abort,
   output logic              underrun
);

   // state | meaning
   // IDLE  | cs_n high, MISO released
   // LOAD  | one clk after cs_fall: first tx word loaded, bit_cnt cleared
   // SHIFT | word transfer in progress; sck_rise samples, sck_fall shifts out

   localparam int CW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

   logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
   logic                   sck_d, cs_d;
   logic                   sck_s, cs_s, mosi_s;
   logic                   sck_rise, sck_fall, cs_fall, cs_rise;

   state_t            state;
   logic [CW-1:0]     bit_cnt;
   logic [WORD_W-1:0] rx_sh;
   logic [WORD_W-1:0] tx_sh;
   logic              word_end;
   logic              load_now;

   always_ff @(posedge clk) begin
      if (rst) begin
         sck_sync  <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sck_d     <= 1'b0;
         cs_d      <= 1'b1;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         sck_d     <= sck_sync[SYNC_STAGES-1];
         cs_d      <= cs_sync[SYNC_STAGES-1];
      end
   end

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign cs_s     = cs_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;
   assign cs_fall  = ~cs_s & cs_d;
   assign cs_rise  = cs_s & ~cs_d;

   // A word that completes together with cs_rise still reports done from IDLE,
   // but the shifter is not reloaded because the frame is already over.
   assign load_now = (state == LOAD) || (word_end && (state == SHIFT));
   assign tx_ready = load_now & tx_valid;
   assign underrun = load_now & ~tx_valid;
   assign miso     = tx_sh[WORD_W-1];
   assign miso_oe  = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         rx_sh    <= '0;
         tx_sh    <= '0;
         word_end <= 1'b0;
         rx_data  <= '0;
         done     <= 1'b0;
         cmd      <= '0;
         word_cnt <= '0;
         abort    <= 1'b0;
      end else begin
         done  <= 1'b0;
         abort <= 1'b0;

         if (word_end) begin
            word_end <= 1'b0;
            done     <= 1'b1;
            rx_data  <= rx_sh;
            if (word_cnt == 8'd0)
               cmd <= rx_sh[WORD_W-1 -: 4];
            if (word_cnt != 8'hFF)
               word_cnt <= word_cnt + 8'd1;
         end

         if (load_now)
            tx_sh <= tx_valid ? tx_data : '0;

         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state    <= LOAD;
                  word_cnt <= 8'd0;
               end
            end
            LOAD: begin
               bit_cnt <= '0;
               state   <= cs_rise ? IDLE : SHIFT;
            end
            SHIFT: begin
               if (sck_rise) begin
                  rx_sh <= {rx_sh[WORD_W-2:0], mosi_s};
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt  <= '0;
                     word_end <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else if (sck_fall && (bit_cnt != '0)) begin
                  // The fall after the last bit is skipped so the reloaded MSB stays on MISO.
                  tx_sh <= {tx_sh[WORD_W-2:0], 1'b0};
               end
               if (cs_rise) begin
                  state <= IDLE;
                  if ((bit_cnt != '0) && !(sck_rise && (bit_cnt == LAST_BIT)))
                     abort <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_word_shifter.sv
// Self-checking bench for spi_word_shifter: single-word vector table plus
// hand-written multi-word, abort, reset and saturation sequences.
module tb_spi_word_shifter;

   logic       clk = 1'b0;
   logic       rst, sck, cs_n, mosi;
   logic       miso, miso_oe;
   logic [7:0] tx_data;
   logic       tx_valid, tx_ready;
   logic [7:0] rx_data;
   logic       done;
   logic [3:0] cmd;
   logic [7:0] word_cnt;
   logic       abort, underrun;

   spi_word_shifter #(.WORD_W(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .done(done), .cmd(cmd),
      .word_cnt(word_cnt), .abort(abort), .underrun(underrun)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int clk_count = 0;
   int n_done = 0, n_ready = 0, n_under = 0, n_abort = 0;
   int last_done_clk = 0;
   int rise_clk = 0;
   logic [7:0] sb[$];

   logic [7:0] fr_rx[260];
   logic [7:0] fr_tx[260];
   logic       fr_val[260];
   logic [7:0] fr_miso[260];

   typedef struct {
      logic [7:0] tx;
      logic       val;
      logic [7:0] mo;
      logic [7:0] exp_miso;
      logic [3:0] exp_cmd;
      int         exp_ready;
      int         exp_under;
   } vec_t;
   vec_t vt[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) clk_count++;

   always @(negedge clk) begin
      if (done) begin
         n_done++;
         last_done_clk = clk_count;
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: got rx_data %0h expected no done", rx_data);
         end else begin
            check("rx_data", {24'd0, rx_data}, {24'd0, sb.pop_front()});
         end
      end
      if (tx_ready) n_ready++;
      if (underrun) n_under++;
      if (abort)    n_abort++;
   end

   initial begin
      #2ms;
      $display("FAIL timeout: got no finish expected finish within 2ms");
      $fatal(1, "timeout");
   end

   task automatic send_bit(input logic b, output logic m);
      mosi = b;
      repeat (5) @(negedge clk);
      m = miso;
      sck = 1'b1;
      repeat (5) @(negedge clk);
      sck = 1'b0;
   endtask

   // early=1 raises cs_n in the same pin instant as the last sck rise.
   task automatic run_frame(input int n, input bit early);
      logic [7:0] m;
      tx_data  = fr_tx[0];
      tx_valid = fr_val[0];
      @(negedge clk);
      cs_n = 1'b0;
      repeat (6) @(negedge clk);
      check("miso_oe_active", {31'd0, miso_oe}, 32'd1);
      for (int w = 0; w < n; w++) begin
         if (w + 1 < n) begin
            tx_data  = fr_tx[w+1];
            tx_valid = fr_val[w+1];
         end
         sb.push_back(fr_rx[w]);
         for (int i = 7; i >= 0; i--) begin
            mosi = fr_rx[w][i];
            repeat (5) @(negedge clk);
            m[i] = miso;
            sck = 1'b1;
            if (i == 0) begin
               rise_clk = clk_count;
               if (early && (w == n - 1)) cs_n = 1'b1;
            end
            repeat (5) @(negedge clk);
            sck = 1'b0;
         end
         check("miso_word", {24'd0, m}, {24'd0, fr_miso[w]});
      end
      if (!early) begin
         repeat (2) @(negedge clk);
         cs_n = 1'b1;
      end
      repeat (10) @(negedge clk);
      check("miso_oe_idle", {31'd0, miso_oe}, 32'd0);
   endtask

   initial begin
      int d0, r0, u0, a0;
      logic [7:0] last_rx;
      logic m;

      vt[0] = '{tx:8'h3C, val:1'b1, mo:8'hA5, exp_miso:8'h3C, exp_cmd:4'hA, exp_ready:2, exp_under:0};
      vt[1] = '{tx:8'hFF, val:1'b1, mo:8'h00, exp_miso:8'hFF, exp_cmd:4'h0, exp_ready:2, exp_under:0};
      vt[2] = '{tx:8'h81, val:1'b0, mo:8'hFF, exp_miso:8'h00, exp_cmd:4'hF, exp_ready:0, exp_under:2};
      vt[3] = '{tx:8'h5A, val:1'b1, mo:8'h3C, exp_miso:8'h5A, exp_cmd:4'h3, exp_ready:2, exp_under:0};

      rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {16'd0, miso, miso_oe, tx_ready, done, abort, underrun, rx_data, cmd, word_cnt[1:0]}, 32'd0);
      check("reset_word_cnt", {24'd0, word_cnt}, 32'd0);

      // single-word vectors, frame ends after the last sck fall
      for (int v = 0; v < 4; v++) begin
         d0 = n_done; r0 = n_ready; u0 = n_under;
         fr_rx[0] = vt[v].mo; fr_tx[0] = vt[v].tx; fr_val[0] = vt[v].val; fr_miso[0] = vt[v].exp_miso;
         run_frame(1, 1'b0);
         check("vec_done", n_done - d0, 1);
         check("vec_latency", last_done_clk - rise_clk, 4);
         check("vec_cmd", {28'd0, cmd}, {28'd0, vt[v].exp_cmd});
         check("vec_word_cnt", {24'd0, word_cnt}, 32'd1);
         check("vec_tx_ready", n_ready - r0, vt[v].exp_ready);
         check("vec_underrun", n_under - u0, vt[v].exp_under);
      end

      // 0xA5 with cs_n rising alongside the last sck rise: done, no abort, no reload
      d0 = n_done; r0 = n_ready; a0 = n_abort;
      fr_rx[0] = 8'hA5; fr_tx[0] = 8'h3C; fr_val[0] = 1'b1; fr_miso[0] = 8'h3C;
      run_frame(1, 1'b1);
      check("cs_edge_done", n_done - d0, 1);
      check("cs_edge_abort", n_abort - a0, 0);
      check("cs_edge_latency", last_done_clk - rise_clk, 4);
      check("cs_edge_tx_ready", n_ready - r0, 1);
      check("cs_edge_rx", {24'd0, rx_data}, 32'hA5);
      check("cs_edge_cmd", {28'd0, cmd}, 32'hA);

      // three-word frame, tx_valid dropped after word 0
      d0 = n_done; r0 = n_ready; u0 = n_under;
      fr_rx[0] = 8'h21; fr_rx[1] = 8'h00; fr_rx[2] = 8'hFF;
      fr_tx[0] = 8'hC3; fr_tx[1] = 8'h77; fr_tx[2] = 8'h77;
      fr_val[0] = 1'b1; fr_val[1] = 1'b0; fr_val[2] = 1'b0;
      fr_miso[0] = 8'hC3; fr_miso[1] = 8'h00; fr_miso[2] = 8'h00;
      run_frame(3, 1'b1);
      check("multi_done", n_done - d0, 3);
      check("multi_cmd", {28'd0, cmd}, 32'h2);
      check("multi_word_cnt", {24'd0, word_cnt}, 32'd3);
      check("multi_tx_ready", n_ready - r0, 1);
      check("multi_underrun", n_under - u0, 2);
      last_rx = 8'hFF;

      // abort after 5 bits of 0x7E
      d0 = n_done; a0 = n_abort;
      tx_data = 8'h11; tx_valid = 1'b1;
      cs_n = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 7; i >= 3; i--) begin
         logic [7:0] w;
         w = 8'h7E;
         send_bit(w[i], m);
      end
      repeat (2) @(negedge clk);
      cs_n = 1'b1;
      repeat (10) @(negedge clk);
      check("abort_pulse", n_abort - a0, 1);
      check("abort_no_done", n_done - d0, 0);
      check("abort_rx_held", {24'd0, rx_data}, {24'd0, last_rx});
      check("abort_cmd_held", {28'd0, cmd}, 32'h2);
      fr_rx[0] = 8'h44; fr_tx[0] = 8'h99; fr_val[0] = 1'b1; fr_miso[0] = 8'h99;
      run_frame(1, 1'b1);
      check("after_abort_cmd", {28'd0, cmd}, 32'h4);

      // reset held 3 clks mid-frame
      tx_data = 8'hE7; tx_valid = 1'b1;
      cs_n = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < 3; i++) send_bit(1'b1, m);
      rst = 1'b1; cs_n = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_outputs", {16'd0, miso, miso_oe, tx_ready, done, abort, underrun, rx_data, cmd, word_cnt[1:0]}, 32'd0);
      check("rst_word_cnt", {24'd0, word_cnt}, 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      d0 = n_done;
      for (int i = 0; i < 10; i++) begin
         sck = 1'b1; repeat (5) @(negedge clk);
         sck = 1'b0; repeat (5) @(negedge clk);
      end
      repeat (10) @(negedge clk);
      check("cs_high_no_done", n_done - d0, 0);
      check("cs_high_oe", {31'd0, miso_oe}, 32'd0);

      // 260-word frame: word_cnt saturates, done keeps pulsing
      d0 = n_done;
      for (int w = 0; w < 260; w++) begin
         fr_rx[w]   = 8'(w * 37 + 5);
         fr_tx[w]   = 8'(w * 13 + 1);
         fr_val[w]  = 1'b1;
         fr_miso[w] = 8'(w * 13 + 1);
      end
      run_frame(260, 1'b0);
      check("sat_done", n_done - d0, 260);
      check("sat_word_cnt", {24'd0, word_cnt}, 32'd255);
      check("sat_cmd", {28'd0, cmd}, {28'd0, fr_rx[0][7:4]});
      check("sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
